// File: rtl/icache_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
package icache_fetch_pkg;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned OFFSET_W   = 6;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned INST_W     = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } fetch_state_e;

  // Little-endian 32-bit word from a line; sel is the word number within the line.
  function automatic logic [INST_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [3:0]        sel);
    return line[{sel, 5'b0} +: INST_W];
  endfunction
endpackage

// File: rtl/icache_fetch_if.sv
// Bundle of the fetch unit's control, memory-port and issue-port signals.
interface icache_fetch_if;
  import icache_fetch_pkg::*;

  logic              rdy;
  logic              rollback;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_pc;
  logic [LINE_W-1:0] mem_line;
  logic              mem_done;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    input  rdy, rollback, redirect_pc, mem_line, mem_done, inst_ready,
    output mem_req, mem_pc, inst_valid, inst, inst_pc
  );

  modport slave (
    output rdy, rollback, redirect_pc, mem_line, mem_done, inst_ready,
    input  mem_req, mem_pc, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: combinational read by index, one synchronous write port.
module icache_line_store
  import icache_fetch_pkg::*;
#(
  parameter  int unsigned LINES = 16,
  localparam int unsigned IW    = $clog2(LINES),
  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINE_W-1:0] data_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/icache_fetch.sv
// Fetch front end: PC, hit/miss FSM, registered instruction output and line request logic.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input  logic            clk,
  input  logic            rst,
  icache_fetch_if.master  io
);
  localparam int unsigned IW    = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IW;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_pc_q, mem_pc_d;
  logic              mem_req_q, mem_req_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              wr_en;
  logic              hit;
  logic              slot_free;

  // A mem_done seen while frozen is not consumed; the controller re-presents it.
  assign wr_en = io.rdy && (state_q == ST_MISS) && io.mem_done;

  icache_line_store #(.LINES(LINES)) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_q[OFFSET_W +: IW]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (mem_pc_q[OFFSET_W +: IW]),
    .wr_tag   (mem_pc_q[ADDR_W-1 -: TAG_W]),
    .wr_data  (io.mem_line)
  );

  assign hit       = rd_valid && (rd_tag == pc_q[ADDR_W-1 -: TAG_W]);
  assign slot_free = !inst_valid_q || io.inst_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_pc_d     = mem_pc_q;
    mem_req_d    = mem_req_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    if (inst_valid_q && io.inst_ready) inst_valid_d = 1'b0;

    if (io.rollback) begin
      pc_d         = io.redirect_pc;
      inst_valid_d = 1'b0;
      mem_req_d    = 1'b0;
      state_d      = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hit) begin
            if (slot_free) begin
              inst_d       = line_word(rd_data, pc_q[OFFSET_W-1:2]);
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + 32'd4;
            end
          end else begin
            state_d   = ST_MISS;
            mem_pc_d  = pc_q;
            mem_req_d = 1'b1;
          end
        end
        ST_MISS: begin
          // Returning to RUN keeps mem_req low for at least one cycle before any new miss.
          if (io.mem_done) begin
            mem_req_d = 1'b0;
            state_d   = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= '0;
      mem_pc_q     <= '0;
      mem_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else if (io.rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_pc_q     <= mem_pc_d;
      mem_req_q    <= mem_req_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign io.mem_req    = mem_req_q;
  assign io.mem_pc     = mem_pc_q;
  assign io.inst_valid = inst_valid_q;
  assign io.inst       = inst_q;
  assign io.inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_icache_fetch.sv
// Directed + randomized bench for icache_fetch with an instruction-stream reference model.
module tb_icache_fetch;
  import icache_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  icache_fetch_if bus();

  icache_fetch #(.LINES(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] exp_pc;
  bit          model_en = 0;
  int          req_count = 0;
  bit          prev_req = 0;

  // memory responder state
  bit          mem_hold = 0;
  bit          served = 0;
  bit          pending = 0;
  int          cnt = 0;
  int          lat_max = 3;

  // per-cycle expectations carried across the edge
  bit          e_frozen, e_hold, e_inv, e_req_low, e_req_stable;
  logic        s_req, s_valid;
  logic [31:0] s_mem_pc, s_inst, s_inst_pc;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
  endfunction

  function automatic logic [511:0] mem_build(input logic [31:0] a);
    logic [511:0] l;
    logic [31:0]  base;
    base = {a[31:6], 6'b0};
    for (int i = 0; i < 64; i++) l[8*i +: 8] = mem_byte(base + 32'(i));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick();
    bit done_acc;
    e_frozen = 0; e_hold = 0; e_inv = 0; e_req_low = 0; e_req_stable = 0;
    if (model_en && !rst) begin
      if (!bus.rdy) begin
        e_frozen  = 1;
        s_req     = bus.mem_req;
        s_mem_pc  = bus.mem_pc;
        s_valid   = bus.inst_valid;
        s_inst    = bus.inst;
        s_inst_pc = bus.inst_pc;
      end else begin
        if (bus.inst_valid && bus.inst_ready) begin
          chk("acc_pc", bus.inst_pc, exp_pc);
          chk("acc_inst", bus.inst, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
        if (bus.rollback) begin
          exp_pc = bus.redirect_pc;
          e_inv  = 1;
        end else if (bus.inst_valid && !bus.inst_ready) begin
          e_hold    = 1;
          s_inst    = bus.inst;
          s_inst_pc = bus.inst_pc;
        end
        if (bus.mem_req && bus.mem_done) e_req_low = 1;
        else if (bus.mem_req && !bus.rollback) begin
          e_req_stable = 1;
          s_mem_pc     = bus.mem_pc;
        end
      end
    end
    done_acc = bus.mem_done && bus.rdy;

    @(posedge clk);
    #1;

    if (e_frozen) begin
      chk("frz_req", bus.mem_req, s_req);
      chk("frz_mem_pc", bus.mem_pc, s_mem_pc);
      chk("frz_valid", bus.inst_valid, s_valid);
      chk("frz_inst", bus.inst, s_inst);
      chk("frz_inst_pc", bus.inst_pc, s_inst_pc);
    end
    if (e_hold) begin
      chk("hold_valid", bus.inst_valid, 1);
      chk("hold_inst", bus.inst, s_inst);
      chk("hold_pc", bus.inst_pc, s_inst_pc);
    end
    if (e_inv) chk("rb_inv", bus.inst_valid, 0);
    if (e_req_low) chk("req_gap", bus.mem_req, 0);
    if (e_req_stable) begin
      chk("req_held", bus.mem_req, 1);
      chk("req_pc_stable", bus.mem_pc, s_mem_pc);
    end

    if (bus.mem_req && !prev_req) req_count++;
    prev_req = bus.mem_req;

    // memory controller: a pulse offered while frozen stays offered
    if (bus.mem_done && !done_acc) begin
      bus.mem_done = 1'b1;
    end else begin
      bus.mem_done = 1'b0;
      if (done_acc) served = 1;
      if (!bus.mem_req) begin
        served  = 0;
        pending = 0;
      end else if (!served && !mem_hold) begin
        if (!pending) begin
          pending = 1;
          cnt     = int'($urandom_range(0, lat_max));
        end
        if (cnt == 0) begin
          bus.mem_done = 1'b1;
          bus.mem_line = mem_build(bus.mem_pc);
          pending      = 0;
        end else begin
          cnt--;
        end
      end
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.inst_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, bus.inst_valid, 1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (!bus.mem_req && n < budget) begin
      tick();
      n++;
    end
    chk(tag, bus.mem_req, 1);
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] pc, input int budget);
    int n = 0;
    while (!(bus.inst_valid && bus.inst_pc == pc) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, bus.inst_pc, pc);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.rollback    = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.rollback    = 1'b0;
  endtask

  initial begin
    logic [31:0] hold_pc, hold_inst;
    int          r0;

    bus.rdy         = 1'b1;
    bus.rollback    = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_done    = 1'b0;
    bus.mem_line    = '0;
    bus.inst_ready  = 1'b1;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", bus.inst_valid, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_mem_pc", bus.mem_pc, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);

    // cold start
    rst      = 1'b0;
    model_en = 1;
    exp_pc   = 32'h0;
    tick();
    chk("cold_req", bus.mem_req, 1);
    chk("cold_mem_pc", bus.mem_pc, 32'h0);
    wait_valid("cold_valid", 20);
    chk("cold_inst0", bus.inst, 32'h03020100);
    chk("cold_pc0", bus.inst_pc, 32'h0);
    tick();
    chk("cold_valid1", bus.inst_valid, 1);
    chk("cold_inst1", bus.inst, 32'h07060504);
    chk("cold_pc1", bus.inst_pc, 32'h4);

    // run across the line boundary
    wait_req("seq_req", 40);
    chk("seq_mem_pc", bus.mem_pc, 32'h40);
    chk("seq_req_count", req_count, 2);
    wait_pc("seq_pc40", 32'h40, 20);
    chk("seq_inst40", bus.inst, mem_word(32'h40));

    // backpressure on a hit
    tick();
    tick();
    bus.inst_ready = 1'b0;
    hold_pc   = bus.inst_pc;
    hold_inst = bus.inst;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", bus.inst_valid, 1);
      chk("bp_pc", bus.inst_pc, hold_pc);
      chk("bp_inst", bus.inst, hold_inst);
    end
    bus.inst_ready = 1'b1;
    tick();
    chk("bp_next_valid", bus.inst_valid, 1);
    chk("bp_next_pc", bus.inst_pc, hold_pc + 32'd4);

    // conflict: same index, different tag
    redirect(32'h0);
    r0 = req_count;
    wait_valid("cf_hit_valid", 10);
    chk("cf_hit_pc", bus.inst_pc, 32'h0);
    chk("cf_hit_noreq", req_count, r0);
    redirect(32'h400);
    wait_req("cf_req1", 10);
    chk("cf_mem_pc1", bus.mem_pc, 32'h400);
    wait_valid("cf_valid1", 20);
    chk("cf_pc1", bus.inst_pc, 32'h400);
    chk("cf_inst1", bus.inst, mem_word(32'h400));
    redirect(32'h0);
    wait_req("cf_req2", 10);
    chk("cf_mem_pc2", bus.mem_pc, 32'h0);
    wait_valid("cf_valid2", 20);
    chk("cf_inst2", bus.inst, 32'h03020100);

    // rollback during MISS
    mem_hold = 1;
    redirect(32'h3000);
    wait_req("rbm_req", 10);
    redirect(32'h1000);
    chk("rbm_drop", bus.mem_req, 0);
    chk("rbm_inv", bus.inst_valid, 0);
    mem_hold = 0;
    wait_req("rbm_req2", 10);
    chk("rbm_mem_pc", bus.mem_pc, 32'h1000);
    wait_valid("rbm_valid", 20);
    chk("rbm_pc", bus.inst_pc, 32'h1000);
    chk("rbm_inst", bus.inst, mem_word(32'h1000));

    // freeze mid-MISS; a rollback offered while frozen must be ignored
    mem_hold = 1;
    redirect(32'h2000);
    wait_req("frz_req_up", 10);
    mem_hold        = 0;
    bus.rdy         = 1'b0;
    bus.rollback    = 1'b1;
    bus.redirect_pc = 32'hDEAD0000;
    hold_pc         = bus.mem_pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz_d_req", bus.mem_req, 1);
      chk("frz_d_mem_pc", bus.mem_pc, hold_pc);
      chk("frz_d_valid", bus.inst_valid, 0);
    end
    bus.rdy      = 1'b1;
    bus.rollback = 1'b0;
    wait_valid("frz_valid", 20);
    chk("frz_pc", bus.inst_pc, 32'h2000);
    chk("frz_inst", bus.inst, mem_word(32'h2000));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.inst_ready = ($urandom_range(0, 99) < 75);
      bus.rdy        = ($urandom_range(0, 99) >= 5);
      bus.rollback   = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 15) == 0)
        bus.redirect_pc = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      else
        bus.redirect_pc = {19'd0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 2'b00};
      tick();
    end
    bus.rdy        = 1'b1;
    bus.rollback   = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_fetch.md
# icache_fetch

Instruction-fetch front end with a direct-mapped instruction line cache. Sits between the issue/decode stage and the memory controller's instruction port. Holds the fetch PC and serves one 32-bit instruction per cycle on a hit. On a miss, requests a whole 64-byte line from the memory controller and installs it. Reorder-buffer rollback redirects the PC.

## Interface
- LINES, 16, number of cache lines; power of two, at least 2
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; when low, all state freezes
- rollback  in  1  ROB flush; redirect to redirect_pc
- redirect_pc  in  32  new fetch PC, sampled when rollback=1
- mem_req  out  1  line request to the memory controller
- mem_pc  out  32  PC of the missing instruction; stable while mem_req=1
- mem_line  in  512  line data; byte i = mem_line[8i+7:8i]
- mem_done  in  1  one-cycle pulse; mem_line is valid in this cycle
- inst_valid  out  1  inst and inst_pc are valid
- inst  out  32  instruction word, little-endian from the line
- inst_pc  out  32  PC of inst
- inst_ready  in  1  downstream accepts when inst_valid && inst_ready

## Operation
- Address split:
  - offset = pc[5:0]
  - index = pc[6+IW-1:6], where IW = log2(LINES)
  - tag = pc[31:6+IW]
- Each line stores valid, tag and 512 data bits. All valid bits clear on reset.
- Hit = valid[index] && tag match. Word select = line[pc[5:2]*32 +: 32].
- PC is assumed 4-byte aligned. pc[1:0] is ignored for the word select.
- FSM states:
  - RUN:
    - Output slot free = !inst_valid || inst_ready.
    - On a hit with the slot free: register inst/inst_pc, set inst_valid, pc <= pc+4 (32-bit wrap).
    - On a hit with the slot not free: hold.
    - On a miss: go to MISS, latch mem_pc <= pc, assert mem_req.
  - MISS:
    - Hold mem_req and mem_pc.
    - On mem_done: write mem_line into line[mem_pc index], set its valid and tag, drop mem_req, return to RUN.
    - The instruction itself is delivered by the next RUN lookup.
- Rollback (highest priority, any state):
  - pc <= redirect_pc, inst_valid <= 0.
  - If in MISS: drop mem_req, go to RUN.
  - Rollback coinciding with mem_done: the line is still installed, but no instruction is emitted.
- mem_req is deasserted for at least one cycle between consecutive requests. The controller treats a continuously held request for an unchanged PC as already served.
- rdy=0: no register changes. Outputs hold their values, and a mem_done pulse in that cycle is ignored. The memory controller is also frozen, so no pulse is lost.

## Timing
- Reset values:
  - pc = 0, state = RUN
  - mem_req = 0, mem_pc = 0
  - inst_valid = 0, inst = 0, inst_pc = 0
  - all valid bits = 0
- Hit latency: 1 cycle from PC to inst_valid. Sustained throughput is 1 instruction per cycle while inst_ready=1.
- Miss: mem_req rises 1 cycle after the miss is detected. The line is written in the mem_done cycle. inst_valid rises 1 cycle after that.
  - Total miss latency is 2 cycles plus the memory controller's service time.
- inst_valid, inst and inst_pc stay stable while inst_valid && !inst_ready.
- A rollback in cycle t: inst_valid=0 at t+1. The first redirected instruction appears no earlier than t+2.

## Structure
- Shared package holds:
  - LINE_BYTES=64, OFFSET_W=6, ADDR_W=32
  - the FSM state encoding (RUN, MISS)
- Sub-module icache_line_store:
  - tag/valid/data arrays
  - combinational read by index
  - synchronous write port
  - synchronous clear of valid bits on reset
- icache_fetch holds the PC, FSM, output register and request logic.

## Test plan
- Cold start, reset then release, inst_ready=1:
  - mem_req=1 with mem_pc=0x00000000.
  - mem_done with byte i = i → inst=0x03020100 at pc 0, then 0x07060504 at pc 4, one per cycle.
- Sequential run across the line boundary 0x3C→0x40: second miss, mem_pc=0x40, mem_req low for at least one cycle between the two requests.
- Backpressure, inst_ready=0 for 3 cycles on a hit: inst/inst_pc held, pc not advanced, no duplicate or skipped instruction.
- Rollback during MISS, redirect_pc=0x1000: mem_req drops next cycle and inst_valid=0. The next request carries mem_pc=0x1000.
- Conflict, LINES=16: fetch 0x0, then redirect to 0x400 (same index, different tag) → miss. Redirect back to 0x0 → miss again, refetched.
- rdy=0 held for 4 cycles mid-MISS: all outputs frozen. Normal completion after rdy=1.
